// File: rtl/uart_pkg.sv
// Shared UART definitions: engine state encoding, parity modes, bit-timing helper, parameter legality check.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per serial bit, truncated; the remainder shows up as a small baud error.
  function automatic int cyc_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // True when the elaboration parameters describe a buildable transmitter/receiver.
  function automatic bit cfg_ok(input int cpb, input int dbits, input int par,
                                input int stops, input int depth);
    return (cpb >= 2) &&
           (dbits >= 5) && (dbits <= 9) &&
           (par >= PAR_NONE) && (par <= PAR_EVEN) &&
           ((stops == 1) || (stops == 2)) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word stream feeding the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: source holds s_valid/s_data until it sees s_ready high at a clock edge.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and full/empty/level flags.
// Latency: a written word is visible on rd_data the cycle after the write edge.
// Backpressure: writes while full and reads while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the addresses match.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: buffered valid/ready words become start/data(LSB first)/parity/stop frames; break generator.
// Latency: a word accepted into an empty FIFO with the engine idle drives tx low from the next clock edge.
// Backpressure: s_ready = !fifo_full; break_req is only honoured between frames, never mid-frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 24_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uart_tx_cfg_if.slave                      s_if,
  input  logic                              break_req,
  output logic                              tx,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  localparam int CYC_PER_BIT = cyc_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW          = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam int BW          = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYC_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_INV  = (PARITY == PAR_ODD);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (!cfg_ok(CYC_PER_BIT, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end

  tx_state_e            state, state_n;
  logic [CW-1:0]        clk_count, clk_count_n;
  logic [BW-1:0]        bit_index, bit_index_n;
  logic                 stop_index, stop_index_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_q, tx_n;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s_if.s_valid && s_if.s_ready),
    .wr_data (s_if.s_data),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_if.s_ready = !fifo_full;
  assign tx           = tx_q;
  assign tx_busy      = (state != ST_IDLE) || !fifo_empty;
  assign bit_end      = (clk_count == CNT_LAST);

  // Engine registers; reset drops any frame in flight and forces the line idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      stop_index <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state      <= state_n;
      clk_count  <= clk_count_n;
      bit_index  <= bit_index_n;
      stop_index <= stop_index_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tx_q       <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line value for the next cycle, so tx stays a pure register.
  always_comb begin
    state_n      = state;
    clk_count_n  = clk_count;
    bit_index_n  = bit_index;
    stop_index_n = stop_index;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    tx_n         = tx_q;
    pop          = 1'b0;

    case (state)
      ST_IDLE: begin
        clk_count_n = '0;
        if (break_req) begin
          state_n = ST_BREAK;
          tx_n    = 1'b0;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_n   = fifo_dout;
          par_bit_n = (^fifo_dout) ^ PAR_INV;
          state_n   = ST_START;
          tx_n      = 1'b0;
        end else begin
          tx_n = 1'b1;
        end
      end

      ST_START: begin
        clk_count_n = clk_count + 1'b1;
        if (bit_end) begin
          clk_count_n = '0;
          bit_index_n = '0;
          state_n     = ST_DATA;
          tx_n        = shreg[0];
        end
      end

      ST_DATA: begin
        clk_count_n = clk_count + 1'b1;
        if (bit_end) begin
          clk_count_n = '0;
          if (bit_index == IDX_LAST) begin
            stop_index_n = 1'b0;
            if (PARITY != PAR_NONE) begin
              state_n = ST_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_index_n = bit_index + 1'b1;
            shreg_n     = shreg >> 1;
            tx_n        = shreg[1];
          end
        end
      end

      ST_PARITY: begin
        clk_count_n = clk_count + 1'b1;
        if (bit_end) begin
          clk_count_n  = '0;
          stop_index_n = 1'b0;
          state_n      = ST_STOP;
          tx_n         = 1'b1;
        end
      end

      ST_STOP: begin
        clk_count_n = clk_count + 1'b1;
        if (bit_end) begin
          clk_count_n = '0;
          if (stop_index == STOP_LAST) begin
            // Chain straight into the next frame so queued words leave with no idle gap.
            if (!break_req && !fifo_empty) begin
              pop       = 1'b1;
              shreg_n   = fifo_dout;
              par_bit_n = (^fifo_dout) ^ PAR_INV;
              state_n   = ST_START;
              tx_n      = 1'b0;
            end else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            stop_index_n = 1'b1;
          end
        end
      end

      ST_BREAK: begin
        clk_count_n = '0;
        if (!break_req) begin
          state_n = ST_MARK;
          tx_n    = 1'b1;
        end else begin
          tx_n = 1'b0;
        end
      end

      ST_MARK: begin
        clk_count_n = clk_count + 1'b1;
        if (bit_end) begin
          clk_count_n = '0;
          state_n     = ST_IDLE;
          tx_n        = 1'b1;
        end
      end

      default: begin
        state_n     = ST_IDLE;
        clk_count_n = '0;
        tx_n        = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at 8 clocks per bit.
// Expected frames go into a queue at stimulus time; a line monitor pops and checks each frame as tx falls.
// Directed cases: single frames, parity, two stop bits, FIFO fill/backpressure, break/mark, mid-frame reset.
module tb_uart_tx_cfg;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       break_req = 1'b0;
  int         sel = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  assign if0.s_data  = s_data;
  assign if1.s_data  = s_data;
  assign if2.s_data  = s_data;
  assign if3.s_data  = s_data[6:0];
  assign if0.s_valid = s_valid && (sel == 0);
  assign if1.s_valid = s_valid && (sel == 1);
  assign if2.s_valid = s_valid && (sel == 2);
  assign if3.s_valid = s_valid && (sel == 3);

  logic       tx0, tx1, tx2, tx3, busy0, busy1, busy2, busy3;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;
  logic       tx_m, busy_m, ready_m;
  logic [2:0] lvl_m;

  uart_tx_cfg #(.CLK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut0 (.clk(clk), .rst_n(rst_n), .s_if(if0), .break_req(break_req && (sel == 0)),
            .tx(tx0), .tx_busy(busy0), .fifo_level(lvl0));
  uart_tx_cfg #(.CLK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut1 (.clk(clk), .rst_n(rst_n), .s_if(if1), .break_req(break_req && (sel == 1)),
            .tx(tx1), .tx_busy(busy1), .fifo_level(lvl1));
  uart_tx_cfg #(.CLK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut2 (.clk(clk), .rst_n(rst_n), .s_if(if2), .break_req(break_req && (sel == 2)),
            .tx(tx2), .tx_busy(busy2), .fifo_level(lvl2));
  uart_tx_cfg #(.CLK_FREQ(800), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_dut3 (.clk(clk), .rst_n(rst_n), .s_if(if3), .break_req(break_req && (sel == 3)),
            .tx(tx3), .tx_busy(busy3), .fifo_level(lvl3));

  // Observe whichever DUT the current case is driving.
  always_comb begin
    tx_m = tx0; busy_m = busy0; ready_m = if0.s_ready; lvl_m = lvl0;
    case (sel)
      1: begin tx_m = tx1; busy_m = busy1; ready_m = if1.s_ready; lvl_m = lvl1; end
      2: begin tx_m = tx2; busy_m = busy2; ready_m = if2.s_ready; lvl_m = lvl2; end
      3: begin tx_m = tx3; busy_m = busy3; ready_m = if3.s_ready; lvl_m = lvl3; end
      default: ;
    endcase
  end

  // kind 0: frame, bits[k] is the line value of bit k in time order; kind 1: break low/high run lengths.
  typedef struct {
    int          kind;
    logic [15:0] bits;
    int          n;
    int          lo;
    int          hi;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int n);
    exp_t e;
    e.kind = 0; e.bits = bits; e.n = n; e.lo = 0; e.hi = 0;
    expq.push_back(e);
  endtask

  task automatic expect_break(input int lo, input int hi);
    exp_t e;
    e.kind = 1; e.bits = '0; e.n = 0; e.lo = lo; e.hi = hi;
    expq.push_back(e);
  endtask

  // Returns at the falling edge just after the accepting clock edge, with s_valid dropped.
  task automatic drive_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    s_data = w; s_valid = 1'b1;
    while (!ready_m && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("push_timeout", 1, 0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic frame_test(input string nm, input logic [7:0] w, input logic [15:0] bits,
                            input int nb, input int len);
    int n;
    expect_frame(bits, nb);
    drive_word(w);
    check({nm, "_busy_on_accept"}, int'(busy_m), 1);
    check({nm, "_tx_high_on_accept"}, int'(tx_m), 1);
    @(negedge clk);
    check({nm, "_tx_low_next_cycle"}, int'(tx_m), 0);
    n = 0;
    while (busy_m && n < 2000) begin @(negedge clk); n++; end
    check({nm, "_busy_cycles"}, n, len);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy_m || expq.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check({nm, "_idle_timeout"}, 1, 0);
    repeat (4) @(negedge clk);
  endtask

  // Line monitor: every frame start pops one expectation and checks tx on every cycle of it.
  initial begin : monitor
    exp_t        e;
    int          bad, lo, hi;
    logic [15:0] obs;
    bit          hold;
    hold = 1'b0;
    forever begin
      if (!hold) @(negedge clk);
      hold = 1'b0;
      if (mon_en && rst_n && tx_m === 1'b0) begin
        if (expq.size() == 0) begin
          check("unexpected_tx_low", 1, 0);
          while (tx_m === 1'b0) @(negedge clk);
        end else begin
          e = expq.pop_front();
          if (e.kind == 0) begin
            bad = 0; obs = '0;
            for (int k = 0; k < e.n * CPB; k++) begin
              if (k > 0) @(negedge clk);
              if (tx_m !== e.bits[k / CPB]) bad++;
              if (k % CPB == CPB / 2) obs[k / CPB] = tx_m;
            end
            n_chk++;
            if (bad != 0) begin
              n_fail++;
              $display("FAIL frame: line bits %b, expected %b (%0d bits, %0d bad cycles)",
                       obs, e.bits, e.n, bad);
            end
          end else begin
            lo = 0;
            while (tx_m === 1'b0 && lo < 5000) begin lo++; @(negedge clk); end
            check("break_low_cycles", lo, e.lo);
            hi = 0;
            while (tx_m === 1'b1 && hi < 5000) begin hi++; @(negedge clk); end
            check("mark_high_cycles", hi, e.hi);
            hold = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i, cnt, peak, t_fall, n, lows;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx_m), 1);
    check("rst_busy", int'(busy_m), 0);
    check("rst_ready", int'(ready_m), 1);
    check("rst_level", int'(lvl_m), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    sel = 0;
    frame_test("t1_8n1", 8'h55, 16'b0000_0010_1010_1010, 10, 80);
    // 8E1 0x07: 0,1,1,1,0,0,0,0,0,P=1,1
    sel = 1;
    frame_test("t2_8e1", 8'h07, 16'b0000_0110_0000_1110, 11, 88);
    // 8O1 0x07: parity 0
    sel = 2;
    frame_test("t2_8o1", 8'h07, 16'b0000_0100_0000_1110, 11, 88);
    // 7N2 0x41: 0,1,0,0,0,0,0,1,1,1
    sel = 3;
    frame_test("t3_7n2", 8'h41, 16'b0000_0011_1000_0010, 10, 80);

    // Six words offered back-to-back into a 4-deep FIFO
    sel = 0;
    i = 0; cnt = 0; peak = 0; t_fall = -1;
    while (i < 6 && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (t_fall < 0 && tx_m == 1'b0) t_fall = cyc;
      if (int'(lvl_m) > peak) peak = int'(lvl_m);
      if (cnt == 6) check("t4_ready_cycle6", int'(ready_m), 0);
      s_data = 8'h10 + 8'(i);
      s_valid = 1'b1;
      if (ready_m) begin
        expect_frame({7'b0, 1'b1, s_data, 1'b0}, 10);
        i++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (busy_m && n < 2000) begin
      if (int'(lvl_m) > peak) peak = int'(lvl_m);
      @(negedge clk);
      n++;
    end
    check("t4_level_peak", peak, 4);
    check("t4_total_cycles", cyc - t_fall, 480);
    wait_idle("t4");

    // Break during a frame: frame A ends at F+80, one idle cycle, low F+81..F+220 (140),
    // break released at edge F+221, then 8 MARK cycles plus the IDLE pop cycle high (9), then B.
    expect_frame({7'b0, 1'b1, 8'hA5, 1'b0}, 10);
    drive_word(8'hA5);
    drive_word(8'h3C);
    expect_break(140, CPB + 1);
    expect_frame({7'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (19) @(negedge clk);
    break_req = 1'b1;
    repeat (200) @(negedge clk);
    break_req = 1'b0;
    wait_idle("t5");

    // Reset during data bit 3 with two words queued
    mon_en = 1'b0;
    drive_word(8'hF0);
    drive_word(8'h11);
    drive_word(8'h22);
    repeat (33) @(negedge clk);
    check("t6_level_before_reset", int'(lvl_m), 2);
    rst_n = 1'b0;
    #1;
    check("t6_tx_async", int'(tx_m), 1);
    check("t6_level", int'(lvl_m), 0);
    check("t6_busy", int'(busy_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) lows++;
    end
    check("t6_no_residual_frame", lows, 0);
    mon_en = 1'b1;

    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a small TX FIFO. Data bits, parity mode and stop-bit count are set at elaboration. A valid/ready byte stream is converted into a serial asynchronous frame, LSB first. It replaces the fixed 8N1 transmitter and adds buffering, back-to-back framing and a line-break generator. It sits between the on-chip command/data source and the board TX pin.

Parameters:
- CLK_FREQ, 24_000_000: system clock in Hz.
- BAUD_RATE, 115200: line rate. CYC_PER_BIT = CLK_FREQ / BAUD_RATE, integer truncation. Elaboration error if CYC_PER_BIT < 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9. Elaboration error outside that range.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Any other value is an elaboration error.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  DATA_BITS  word to transmit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a word. Equals !full.
- break_req  in  1  level request to hold the line low (break).
- tx  out  1  serial line. Idle high.
- tx_busy  out  1  high when the engine is not IDLE or the FIFO is not empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of words in the FIFO.

Behaviour:
- Reset, asynchronous: tx=1, tx_busy=0, s_ready=1, fifo_level=0, state=IDLE, all counters 0, FIFO emptied.
- A reset asserted mid-frame drops the frame immediately. tx goes high asynchronously.
- Push rule: a word is written on any edge where s_valid && s_ready.
  - A push while full is impossible, because s_ready=0.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- Engine states: IDLE, START, DATA, PARITY, STOP, BREAK, MARK. Encodings live in the shared package.
- IDLE:
  - If break_req=1, go to BREAK. Break has priority over a non-empty FIFO.
  - Otherwise, if the FIFO is not empty: pop the head into the shift register, go to START, tx<=0.
  - Latency: a word pushed at edge E0 into an empty FIFO with an idle engine drives tx low from edge E1.
- Bit timing: every serial bit lasts exactly CYC_PER_BIT clocks. clk_count runs 0..CYC_PER_BIT-1 and has width $clog2(CYC_PER_BIT).
- START: one bit time of tx=0, then DATA.
- DATA:
  - Send DATA_BITS bits, LSB first. bit_index runs 0..DATA_BITS-1.
  - Next state is PARITY if PARITY != 0, else STOP.
- PARITY: one bit time.
  - Even parity: bit = XOR of all data bits.
  - Odd parity: bit = inverse of that XOR.
- STOP: STOP_BITS bit times of tx=1. On the last cycle of the last stop bit:
  - If break_req=0 and the FIFO is not empty, pop and go directly to START. No idle gap between frames.
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CYC_PER_BIT clocks.
- break_req sampling: sampled only in IDLE and at the end of STOP. It never truncates a frame in progress.
- BREAK: tx=0 while break_req=1. When break_req=0 is sampled, go to MARK.
- MARK: tx=1 for one bit time, then IDLE.
- FIFO in BREAK/MARK: not popped; pushes are still accepted.
- tx source: tx is registered and driven from the state/shift register only. No combinational path from inputs to tx.

Decomposition:
- Shared package uart_pkg contains:
  - state encoding localparams;
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - function cyc_per_bit(clk_freq, baud);
  - the elaboration-time parameter checks.
- One sub-module, uart_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Behaviour: single clock, write and read pointers one bit wider than the address, full/empty/level outputs.
  - Reused later by the receiver.

Test Plan:
All scenarios use CLK_FREQ=800 and BAUD_RATE=100, giving CYC_PER_BIT=8.
1. 8N1 (defaults), push 0x55 into an idle block -> tx low one cycle after accept; bit sequence 0,1,0,1,0,1,0,1,0,1, each held 8 clocks; tx_busy falls exactly 80 clocks after tx fell.
2. PARITY=2, push 0x07 -> parity bit 1, frame 88 clocks. Repeat with PARITY=1 -> parity bit 0.
3. DATA_BITS=7, STOP_BITS=2, push 0x41 -> bits 0,1,0,0,0,0,0,1,1,1, frame 80 clocks.
4. Depth 4, hold s_valid for 6 consecutive cycles:
   - push 0 pops at E1; pushes 1-4 accepted; s_ready=0 on cycle 6; fifo_level peaks at 4;
   - after s_ready returns high, complete the 6th push;
   - 6 frames back-to-back with no high gap beyond stop bits, 480 clocks total.
5. Assert break_req mid-frame for 200 clocks -> current frame completes intact; tx then low until release; then 8 clocks high (MARK); then queued data resumes.
6. Assert rst_n=0 during DATA bit 3 with 2 words queued -> tx=1 immediately, fifo_level=0, tx_busy=0; no residual frame after rst_n deasserts.
